// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the UART receive front end and its consumer.
// The receiver drives data/valid as master; the consumer answers with ready.
interface uart_rx_deframer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8N1, LSB first, mid-bit sampling of a synchronized line,
// one-entry valid/ready holding register, single-cycle framing-error/overrun pulses.
module uart_rx_deframer #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rs232_rx,
  uart_rx_deframer_if.master        rx,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  logic          sync1_r;
  logic          rxs_r;
  logic [1:0]    fill_cnt_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          frame_err_r;
  logic          overrun_r;
  logic          busy_r;

  logic          sync_full_s;
  logic          half_tick_s;
  logic          bit_tick_s;
  logic          baud_clr_s;
  logic          bit_clr_s;
  logic          shift_en_s;
  logic          good_stop_s;
  logic          bad_stop_s;
  logic          accept_s;
  logic          load_s;
  logic          drop_s;

  assign half_tick_s = (baud_cnt_r == HALF_LAST);
  assign bit_tick_s  = (baud_cnt_r == BIT_LAST);
  // The synchronizer holds its reset value for two edges after reset; the line
  // is trusted only once real pin samples have reached rxs.
  assign sync_full_s = (fill_cnt_r == 2'd2);

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rs232_rx;
      rxs_r   <= sync1_r;
    end
  end

  // Counts synchronizer fill after reset, saturating once both stages hold pin data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt_r <= 2'd0;
    end else if (!sync_full_s) begin
      fill_cnt_r <= fill_cnt_r + 2'd1;
    end else begin
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= WAIT_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s = state_r;
    baud_clr_s  = 1'b0;
    bit_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    good_stop_s = 1'b0;
    bad_stop_s  = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        baud_clr_s = 1'b1;
        if (sync_full_s && rxs_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      IDLE: begin
        baud_clr_s = 1'b1;
        if (!rxs_r) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (half_tick_s) begin
          if (rxs_r) begin
            state_nxt_s = IDLE;
          end else begin
            baud_clr_s  = 1'b1;
            bit_clr_s   = 1'b1;
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (bit_tick_s) begin
          if (rxs_r) begin
            good_stop_s = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            bad_stop_s  = 1'b1;
            state_nxt_s = WAIT_IDLE;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        baud_clr_s  = 1'b1;
        state_nxt_s = WAIT_IDLE;
      end
    endcase
  end

  // Baud counter wraps on every sample so sample points stay one bit period apart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
    end else if (baud_clr_s || bit_tick_s) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + CW'(1);
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
    end else if (bit_clr_s) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= shift_r;
    end else if (shift_en_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shift_r   <= {rxs_r, shift_r[7:1]};
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shift_r   <= shift_r;
    end
  end

  assign accept_s = valid_r & rx.rx_ready;
  assign load_s   = good_stop_s & (~valid_r | rx.rx_ready);
  assign drop_s   = good_stop_s & valid_r & ~rx.rx_ready;

  // Holding register: a load wins over a same-cycle accept, so valid stays high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else if (load_s) begin
      data_r  <= shift_r;
      valid_r <= 1'b1;
    end else if (accept_s) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  // Status pulses and busy flag, registered from this cycle's decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      frame_err_r <= bad_stop_s;
      overrun_r   <= drop_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign rx.rx_data  = data_r;
  assign rx.rx_valid = valid_r;
  assign frame_err   = frame_err_r;
  assign overrun     = overrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized bench for uart_rx_deframer: a frame-level event model predicts the
// holding register and status pulses every cycle; directed scenarios pin the model.
module tb_uart_rx_deframer;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;   // 16 clocks per bit
  localparam int HALF     = CPB / 2;
  // Stop-sample result appears this many edges after the edge preceding the start bit.
  localparam int LAT      = 3 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic rst_n;
  logic rs232_rx;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rx_deframer_if rx_if ();

  uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .rx        (rx_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Expected frame outcomes keyed by edge: 1 = good byte, 2 = framing error.
  int         ev_kind [int];
  logic [7:0] ev_data [int];

  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;
  logic [7:0] got_q [$];
  int         ferr_seen = 0;
  int         ovr_seen  = 0;
  int         rise_cnt  = 0;
  int         rise_edge = 0;
  logic [7:0] rise_data;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Model update on each edge, then comparison well before the next edge.
  initial begin
    logic r, rd;
    forever begin
      @(posedge clk);
      edge_n++;
      r  = rst_n;
      rd = rx_if.rx_ready;
      if (r !== 1'b1) begin
        m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
      end else begin
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (m_valid && rd) got_q.push_back(m_data);
        if (ev_kind.exists(edge_n) && ev_kind[edge_n] == 1) begin
          if (!m_valid || rd) begin
            m_valid = 1'b1;
            m_data  = ev_data[edge_n];
          end else begin
            m_ovr = 1'b1;
          end
        end else if (ev_kind.exists(edge_n) && ev_kind[edge_n] == 2) begin
          m_ferr = 1'b1;
          if (m_valid && rd) m_valid = 1'b0;
        end else if (m_valid && rd) begin
          m_valid = 1'b0;
        end
      end
      #2;
      check("rx_valid", rx_if.rx_valid, m_valid);
      if (m_valid) check("rx_data", rx_if.rx_data, m_data);
      check("frame_err", frame_err, m_ferr);
      check("overrun", overrun, m_ovr);
      check("flags_exclusive", frame_err & overrun, 1'b0);
      if (frame_err === 1'b1) ferr_seen++;
      if (overrun === 1'b1) ovr_seen++;
      if (rx_if.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
        rise_cnt++;
        rise_edge = edge_n;
        rise_data = rx_if.rx_data;
      end
      prev_valid = rx_if.rx_valid;
    end
  end

  task automatic idle_cycles(input int n);
    rs232_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rs232_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    int k;
    k = edge_n;
    if (stop_ok) begin
      ev_kind[k + LAT] = 1;
      ev_data[k + LAT] = d;
    end else begin
      ev_kind[k + LAT] = 2;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
  endtask

  logic [7:0] exp_bytes [8];
  logic       rnd_done;

  initial begin
    int k0, f0, o0, r0;
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    rx_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", rx_if.rx_valid, 1'b0);
    check("reset_rx_data", rx_if.rx_data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b1);
    rst_n = 1'b1;
    idle_cycles(CPB);
    check("idle_busy", busy, 1'b0);

    // Basic frame with fixed latency: 3 + 8 + 9*16 = 155 edges.
    rx_if.rx_ready = 1'b1;
    k0 = edge_n;
    send_frame(8'hA5, 1'b1);
    idle_cycles(CPB);
    check("basic_latency", rise_edge - k0, 155);
    check("basic_data", rise_data, 8'hA5);

    // Glitch shorter than half a bit is rejected.
    r0 = rise_cnt;
    rs232_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_cycles(2 * CPB);
    check("glitch_no_byte", rise_cnt - r0, 0);
    check("glitch_busy", busy, 1'b0);
    send_frame(8'h3C, 1'b1);
    idle_cycles(CPB);
    check("glitch_then_byte", rise_cnt - r0, 1);

    // Framing error, line held low, then a good frame.
    f0 = ferr_seen;
    r0 = rise_cnt;
    send_frame(8'h55, 1'b0);
    rs232_rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    idle_cycles(CPB);
    check("ferr_pulses", ferr_seen - f0, 1);
    check("ferr_no_byte", rise_cnt - r0, 0);
    send_frame(8'h81, 1'b1);
    idle_cycles(CPB);

    // Overrun with the consumer stalled.
    o0 = ovr_seen;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle_cycles(CPB);
    check("ovr_pulses", ovr_seen - o0, 1);
    check("ovr_held_valid", rx_if.rx_valid, 1'b1);
    check("ovr_held_data", rx_if.rx_data, 8'h12);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    idle_cycles(2);
    check("ovr_drained", rx_if.rx_valid, 1'b0);

    // Reset in the middle of data bit 3 of 0xF0.
    rx_if.rx_ready = 1'b1;
    f0 = ferr_seen; o0 = ovr_seen; r0 = rise_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rs232_rx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rst_n = 1'b0;
    ev_kind.delete();
    ev_data.delete();
    repeat (2) @(negedge clk);
    check("midrst_valid", rx_if.rx_valid, 1'b0);
    check("midrst_busy", busy, 1'b1);
    rst_n = 1'b1;
    repeat (CPB - HALF / 2 - 2) @(negedge clk);
    check("midrst_wait_idle", busy, 1'b1);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    idle_cycles(CPB);
    check("midrst_no_byte", rise_cnt - r0, 0);
    check("midrst_no_flags", (ferr_seen - f0) + (ovr_seen - o0), 0);
    send_frame(8'hFF, 1'b1);
    idle_cycles(CPB);

    // Back-to-back frames with zero idle.
    r0 = rise_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle_cycles(2 * CPB);
    check("b2b_count", rise_cnt - r0, 3);
    check("b2b_last", rise_data, 8'h5A);

    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h3C; exp_bytes[2] = 8'h81; exp_bytes[3] = 8'h12;
    exp_bytes[4] = 8'hFF; exp_bytes[5] = 8'h00; exp_bytes[6] = 8'hFF; exp_bytes[7] = 8'h5A;
    check("directed_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("directed_byte", got_q[i], exp_bytes[i]);
    got_q.delete();

    // Random bytes, random stop bits, random gaps and random consumer stalls.
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          rx_if.rx_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          logic [7:0] b;
          logic       ok;
          b  = 8'($urandom);
          ok = ($urandom_range(0, 5) != 0);
          send_frame(b, ok);
          if (!ok) begin
            rs232_rx = 1'b0;
            repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
            idle_cycles(CPB);
          end else begin
            idle_cycles($urandom_range(0, 4));
          end
        end
        rnd_done = 1'b1;
      end
    join
    rx_if.rx_ready = 1'b1;
    idle_cycles(4 * CPB);
    check("final_drained", rx_if.rx_valid, 1'b0);
    check("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive front end of the UART top level. Consumes the raw asynchronous serial line (8 data bits, no parity, 1 stop bit, LSB first). Delivers each received byte through a one-entry valid/ready holding register to the downstream loopback/transmit stage. Flags framing errors and overruns as single-cycle pulses.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line bit rate in bits/s
CLKS_PER_BIT, CLK_FREQ/BAUD (5208 at defaults), derived localparam; clocks per bit period
HALF_BIT, CLKS_PER_BIT/2 (2604), derived localparam; start-bit mid-point delay

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
rs232_rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte; valid only while rx_valid=1
rx_valid  output  1  holding register occupied
rx_ready  input  1  consumer accepts the byte; transfer occurs on clk edge with rx_valid & rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full
busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n; there is no asynchronous reset.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - 2-FF synchronizer flops=1.
  - bit counter=0, baud counter=0.
  - state=WAIT_IDLE, so busy=1 until the line is seen high.
- rs232_rx passes through a 2-FF synchronizer. All decisions use the synchronized line rxs, which lags the pin by 2 cycles.
- FSM states and transitions:
  - WAIT_IDLE: go to IDLE when rxs=1.
  - IDLE: when rxs=0, clear the baud counter and go to START.
  - START: count HALF_BIT-1 cycles, then sample rxs.
    - rxs=1: false start (glitch). Go to IDLE; no flags raised.
    - rxs=0: clear the baud counter and go to DATA.
  - DATA: count CLKS_PER_BIT-1 cycles, then sample rxs into shift register bit[n], with n=0..7 (LSB first).
    - After bit 7, go to STOP.
  - STOP: count CLKS_PER_BIT-1 cycles, then sample rxs.
    - rxs=1 (good frame): deliver the byte per the holding rules below, then go to IDLE.
    - rxs=0: pulse frame_err, discard the byte, go to WAIT_IDLE (break or line-low handling).
- Holding register rules, applied at the STOP good-sample cycle:
  - If rx_valid=0, or rx_valid & rx_ready in that same cycle: load rx_data and set rx_valid=1 on the next edge. A simultaneous accept and load keeps rx_valid=1 with the new byte.
  - If rx_valid=1 & rx_ready=0: the new byte is dropped, overrun pulses, and rx_data/rx_valid are unchanged.
- rx_valid clears on the clk edge where rx_valid & rx_ready, unless a load happens in the same cycle.
- rx_data is stable while rx_valid=1.
- Latency: rx_valid rises 1 cycle after the mid-stop sample, i.e. about 9.5 bit times + 3 cycles after the start-bit falling edge on the pin.
- Sampling window: the baud counter reaches CLKS_PER_BIT-1 and wraps to 0, so each sample point is exactly CLKS_PER_BIT cycles after the previous one.
- The receiver re-arms in IDLE 1 cycle after the stop sample, so back-to-back frames with zero idle are received.
- Reset mid-frame: the partial byte is lost and no flags are raised. Via WAIT_IDLE, the residual low bits of the interrupted frame cannot trigger a start; the next start is detected only after the line is seen high.
- frame_err and overrun are never asserted in the same cycle.

Test Plan:
1. Basic frame: rx_ready=1, send 0xA5 at 104167 ns/bit → one-cycle rx_valid with rx_data=8'hA5; frame_err=0, overrun=0.
2. Glitch rejection: pull the line low for 1000 clocks, then high, then send 0x3C → no rx_valid for the glitch, busy returns to 0, and exactly one byte 0x3C is received.
3. Framing error: send 0x55 with stop bit=0, hold the line low 2 more bit times, release high, then send 0x81 → one frame_err pulse, no byte delivered for 0x55, then 0x81 received correctly.
4. Overrun: rx_ready=0, send 0x12 then 0x34 → rx_valid stays 1 with 0x12 and overrun pulses once at the 0x34 stop sample. Then raise rx_ready=1 for 1 cycle → rx_valid=0 and no 0x34 appears.
5. Reset mid-frame: assert rst_n=0 for 2 cycles during data bit 3 of 0xF0 → all outputs return to reset values and no byte or flag from the remainder. The following 0xFF frame is received correctly.
6. Back-to-back, zero idle, rx_ready=1: send 0x00, 0xFF, 0x5A → three rx_valid pulses in order with the correct data and no flags.
